// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: writeback source encoding and load funct3 codes.
package riscv_pkg;

  localparam int unsigned INSTRET_W = 64;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction: picks the addressed lane of an aligned
// doubleword, extends it, and flags misaligned or illegal load types.
module load_extract
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [2:0]            funct3,
  input  logic [2:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  fault
);

  logic [DATA_WIDTH-1:0] shifted;

  // Bring the addressed byte down to bit 0; the extension below trims it.
  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LH: begin
        data  = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        fault = offset[0];
      end
      F3_LHU: begin
        data  = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        fault = offset[0];
      end
      F3_LW: begin
        data  = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
        fault = |offset[1:0];
      end
      F3_LWU: begin
        data  = {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]};
        fault = |offset[1:0];
      end
      F3_LD: begin
        data  = shifted;
        fault = |offset;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback source, gates faulting loads
// and x0 writes, and counts retired instructions.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     m_valid,
  input  logic                     m_RegWrite,
  input  logic [1:0]               m_wb_sel,
  input  logic [2:0]               m_funct3,
  input  logic [ADDRESS_WIDTH-1:0] m_rd,
  input  logic [DATA_WIDTH-1:0]    m_alu_result,
  input  logic [DATA_WIDTH-1:0]    m_load_word,
  input  logic [DATA_WIDTH-1:0]    m_pc4,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0]    wd,
  output logic                     wb_valid,
  output logic                     misalign,
  output logic [INSTRET_W-1:0]     instret
);

  logic                     regwrite_q, regwrite_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;
  logic [DATA_WIDTH-1:0]    wd_q, wd_d;
  logic                     valid_q, valid_d;
  logic                     misalign_q, misalign_d;
  logic [INSTRET_W-1:0]     instret_q, instret_d;

  logic [DATA_WIDTH-1:0]    load_data_c;
  logic                     ext_fault_c;
  logic                     fault_c;
  logic                     retire_c;
  logic [DATA_WIDTH-1:0]    sel_data_c;

  load_extract #(.DATA_WIDTH(DATA_WIDTH)) u_load_extract (
    .funct3 (m_funct3),
    .offset (m_alu_result[2:0]),
    .word   (m_load_word),
    .data   (load_data_c),
    .fault  (ext_fault_c)
  );

  // Extraction faults only matter for real load instructions.
  assign fault_c  = m_valid & (m_wb_sel == WB_LOAD) & ext_fault_c;
  assign retire_c = m_valid & ~fault_c;

  // Reserved encoding 11 falls through to the ALU result.
  always_comb begin
    case (m_wb_sel)
      WB_LOAD: sel_data_c = load_data_c;
      WB_PC4:  sel_data_c = m_pc4;
      default: sel_data_c = m_alu_result;
    endcase
  end

  // Next state: flush beats stall, stall beats capture.
  always_comb begin
    regwrite_d = regwrite_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;
    instret_d  = instret_q;
    if (flush) begin
      regwrite_d = 1'b0;
      wa_d       = '0;
      wd_d       = '0;
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end else if (!stall) begin
      valid_d    = m_valid;
      wa_d       = m_rd;
      regwrite_d = m_valid & m_RegWrite & (m_rd != '0) & ~fault_c;
      misalign_d = fault_c;
      wd_d       = retire_c ? sel_data_c : '0;
      if (retire_c) instret_d = instret_q + INSTRET_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign wb_valid = valid_q;
  assign misalign = misalign_q;
  assign instret  = instret_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback pipeline stage between data-memory access and `regfile`. It registers the memory-stage result, extracts and extends load data, selects the writeback source, and drives the register file write port (`RegWrite`, `wa`, `wd`). It also suppresses writes to x0 and misaligned loads, handles stall and flush, and keeps a retired-instruction counter.

## Interface
Parameters:
- `DATA_WIDTH`, 64, register and datapath width.
- `ADDRESS_WIDTH`, 5, register index width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold all stage registers.
- `flush` in 1: replace captured instruction with a bubble.
- `m_valid` in 1: memory stage holds a real instruction.
- `m_RegWrite` in 1: instruction writes a destination register.
- `m_wb_sel` in 2: writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- `m_funct3` in 3: load type (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110, 111 illegal).
- `m_rd` in `ADDRESS_WIDTH`: destination register index.
- `m_alu_result` in `DATA_WIDTH`: ALU result; bits [2:0] give the load byte offset.
- `m_load_word` in `DATA_WIDTH`: raw aligned doubleword from data memory.
- `m_pc4` in `DATA_WIDTH`: PC+4 for JAL/JALR.
- `RegWrite` out 1: regfile write enable.
- `wa` out `ADDRESS_WIDTH`: regfile write address.
- `wd` out `DATA_WIDTH`: regfile write data.
- `wb_valid` out 1: stage holds a real instruction (used for forwarding/hazard logic).
- `misalign` out 1: the held instruction was a faulting load.
- `instret` out 64: retired-instruction count.

## Operation
- Capture condition: rising edge with `reset`=0, `flush`=0, `stall`=0. The stage latches `wb_valid`←`m_valid`, `wa`←`m_rd`, and `wd`←the selected source.
- Load extraction, with byte offset `o`=`m_alu_result[2:0]`:
  - LB/LBU: byte `o`, sign- or zero-extended.
  - LH/LHU: halfword at `o`; requires `o[0]`=0.
  - LW/LWU: word at `o`; requires `o[1:0]`=0.
  - LD: full doubleword; requires `o`=0.
  - funct3 111 is a fault.
- Fault: `m_wb_sel`=01, `m_valid`=1, and the alignment rule fails or funct3 is 111. On capture: `misalign`=1, `RegWrite`=0, `wd`=0.
- `RegWrite` captured as `m_valid & m_RegWrite & (m_rd != 0) & ~fault`. No write to x0 is ever issued.
- When `m_valid`=0, `RegWrite`, `wd` and `misalign` capture 0.
- `instret` increments by 1 on each capture with `m_valid`=1 and no fault. It wraps from 2^64-1 to 0.
- Priority is `reset` > `flush` > `stall` > capture.
  - `reset`: all outputs become 0, including `instret`.
  - `flush`: `wb_valid`, `RegWrite` and `misalign` become 0; `wa`/`wd` become 0; `instret` holds.
  - `stall`: every register holds. A held `RegWrite`=1 rewrites the same value, which is idempotent. `instret` does not increment.
- A flush asserted during a stall produces the bubble anyway.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- `regfile` commits on the falling edge in the middle of that cycle. Its read ports therefore return the new value in the second half of the same cycle, so decode needs no WB→ID bypass.
- All outputs are registered; there are no combinational input→output paths.
- Reset values: `RegWrite`=0, `wa`=0, `wd`=0, `wb_valid`=0, `misalign`=0, `instret`=0. They are valid from the first edge at which `reset` is sampled high.
- `reset` asserted mid-operation discards the held instruction; no write is issued in the following cycle.

## Structure
- Shared package `riscv_pkg`:
  - `wb_sel_t` enum (WB_ALU, WB_LOAD, WB_PC4).
  - Load funct3 constants `F3_LB`…`F3_LWU`.
- Sub-module `load_extract`: purely combinational, taking `funct3`, `offset`, `word` and producing `data` and `fault`. Instantiated once and also reusable by a future forwarding path.
- The top-level holds the pipeline registers, the capture priority logic and the `instret` counter.

## Test plan
- Reset, then hold `reset`=1 with arbitrary inputs → all outputs 0. Then ALU write x5=0x1234 → `RegWrite`=1, `wa`=5, `wd`=0x1234 one cycle later, and `instret`=1.
- Loads from `m_load_word`=0x8877_6655_4433_2211, with the offset varied:
  - LB offset 7 → `wd`=0xFFFF_FFFF_FFFF_FF88.
  - LBU offset 7 → 0x88.
  - LH offset 6 → 0xFFFF_FFFF_FFFF_8877.
  - LWU offset 4 → 0x8877_6655.
  - LD offset 0 → full word.
- LW at offset 2, and funct3 111 → `misalign`=1, `RegWrite`=0, `instret` unchanged.
- Write to x0 with `m_RegWrite`=1 → `RegWrite`=0, `wb_valid`=1, `instret` increments.
- Stall for 3 cycles while inputs change → outputs frozen and `instret` constant. Then `flush`+`stall` together → bubble (`wb_valid`=0, `RegWrite`=0).
- JAL writeback with `m_wb_sel`=10, `m_pc4`=0x1004, rd=1 → `wd`=0x1004. End-to-end with `regfile`: a read of x1 in the same cycle, after the falling edge, returns 0x1004.
